// File: rtl/burstbuffer_to_bsig.sv
// burstbuffer_to_bsig
// Write-side burst framer between the sample packer and the DMA staging FIFO.
// Incoming words are grouped into bursts of cfg_brst_words_z+1 words. A burst
// that finds a free ring slot on its first word is written to the FIFO (FILL).
// Otherwise it is dropped whole (SKIP). Each completed burst flips one level
// signal (fill or skip), so the DMA side can sample it asynchronously.
// mlowmrk flips on every full payload chunk inside a filled burst, except on
// the chunk that ends the burst.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   dma_en              0 = flush/idle; configuration is captured while low
//   cfg_*               burst length, ring size, payload chunk size, mlowmrk disable
//   burst_release       one ring slot returned by the DMA side
//   in_valid, in_data   input word stream (no backpressure)
//   fifo_wr_en/_data    registered FIFO write port
//   fifo_burst_skip/fill/mlowmrk   toggle-encoded burst events
//   stat_skipped        saturating count of skipped bursts
//   credits             free ring slots
module burstbuffer_to_bsig #(
    parameter int DATA_BITS        = 4,
    parameter int BUFFER_SIZE_BITS = 16,
    parameter int RING_BITS        = 6,
    parameter int EN_LOWWMRK       = 1,
    parameter int SKIP_CNT_BITS    = 24
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  dma_en,
    input  logic [1:0]                            cfg_max_payload_sz,
    input  logic                                  cfg_dis_lowwmrk,
    input  logic [BUFFER_SIZE_BITS-DATA_BITS-1:0] cfg_brst_words_z,
    input  logic [RING_BITS-1:0]                  cfg_ring_bursts_z,
    input  logic                                  burst_release,
    input  logic                                  in_valid,
    input  logic [(8<<DATA_BITS)-1:0]             in_data,
    output logic                                  fifo_wr_en,
    output logic [(8<<DATA_BITS)-1:0]             fifo_wr_data,
    output logic                                  fifo_burst_skip,
    output logic                                  fifo_burst_fill,
    output logic                                  fifo_burst_mlowmrk,
    output logic [SKIP_CNT_BITS-1:0]              stat_skipped,
    output logic [RING_BITS:0]                    credits
);

    localparam int WORD_W  = 8 << DATA_BITS;
    localparam int CNT_W   = BUFFER_SIZE_BITS - DATA_BITS;
    // Largest chunk is 1024 bytes; at one byte per word that is 1024 words.
    localparam int CHUNK_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SKIP = 2'd2
    } state_t;

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         word_cnt_reg, word_cnt_next;
    logic [CHUNK_W-1:0]       chunk_cnt_reg, chunk_cnt_next;
    logic [RING_BITS:0]       credits_reg, credits_next;
    logic [SKIP_CNT_BITS-1:0] stat_reg, stat_next;
    logic                     wr_en_reg, wr_en_next;
    logic [WORD_W-1:0]        wr_data_reg, wr_data_next;
    logic                     skip_reg, skip_next;
    logic                     fill_reg, fill_next;
    logic                     mlow_reg, mlow_next;

    // Configuration captured while dma_en is low, stable during a run.
    logic [1:0]               cfg_sz_reg;
    logic                     cfg_dis_reg;
    logic [CNT_W-1:0]         cfg_brst_z_reg;
    logic [RING_BITS-1:0]     cfg_ring_z_reg;

    logic                     lowwmrk_allowed;
    logic [CHUNK_W-1:0]       chunk_raw;
    logic [CHUNK_W-1:0]       chunk_words;
    logic [RING_BITS:0]       credit_max;
    logic [RING_BITS:0]       credits_eff;
    logic [CNT_W-1:0]         cur_idx;
    logic                     is_last;
    logic                     chunk_done;
    logic                     take_slot;
    logic                     do_write;
    logic                     do_drop;

    generate
        if (EN_LOWWMRK != 0) begin : g_lowwmrk
            assign lowwmrk_allowed = ~cfg_dis_reg;
        end else begin : g_no_lowwmrk
            assign lowwmrk_allowed = 1'b0;
        end
    endgenerate

    // Chunk length in words, never below one word.
    assign chunk_raw   = (CHUNK_W'(128) << cfg_sz_reg) >> DATA_BITS;
    assign chunk_words = (chunk_raw == '0) ? CHUNK_W'(1) : chunk_raw;

    // A release is ignored once every slot is already free.
    assign credit_max  = {1'b0, cfg_ring_z_reg} + (RING_BITS+1)'(1);
    assign credits_eff = credits_reg +
                         (RING_BITS+1)'(burst_release && (credits_reg < credit_max));

    // The first word of a burst (seen in IDLE) has index 0.
    assign cur_idx    = (state_reg == ST_IDLE) ? '0 : word_cnt_reg;
    assign is_last    = (cur_idx == cfg_brst_z_reg);
    assign chunk_done = ((chunk_cnt_reg + CHUNK_W'(1)) == chunk_words);

    // The fill/skip decision is made only on the first word of a burst.
    assign take_slot = (state_reg == ST_IDLE) && (credits_eff != '0);
    assign do_write  = in_valid && ((state_reg == ST_FILL) || take_slot);
    assign do_drop   = in_valid && !do_write;

    always_comb begin
        state_next     = state_reg;
        word_cnt_next  = word_cnt_reg;
        chunk_cnt_next = chunk_cnt_reg;
        credits_next   = credits_reg;
        stat_next      = stat_reg;
        wr_en_next     = 1'b0;
        wr_data_next   = wr_data_reg;
        skip_next      = skip_reg;
        fill_next      = fill_reg;
        mlow_next      = mlow_reg;

        if (!dma_en) begin
            // Flush: any partial burst is abandoned without a toggle.
            state_next     = ST_IDLE;
            word_cnt_next  = '0;
            chunk_cnt_next = '0;
            credits_next   = {1'b0, cfg_ring_bursts_z} + (RING_BITS+1)'(1);
            stat_next      = '0;
        end else begin
            credits_next = credits_eff;
            if (in_valid) begin
                word_cnt_next = cur_idx + CNT_W'(1);
                if (is_last) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = do_write ? ST_FILL : ST_SKIP;
                end
            end

            if (take_slot && in_valid) begin
                credits_next = credits_eff - (RING_BITS+1)'(1);
            end

            if (do_write) begin
                wr_en_next   = 1'b1;
                wr_data_next = in_data;
                if (chunk_done || is_last) begin
                    chunk_cnt_next = '0;
                    // The burst-ending word reports fill instead of mlowmrk.
                    if (chunk_done && !is_last && lowwmrk_allowed) begin
                        mlow_next = ~mlow_reg;
                    end
                end else begin
                    chunk_cnt_next = chunk_cnt_reg + CHUNK_W'(1);
                end
                if (is_last) begin
                    fill_next = ~fill_reg;
                end
            end

            if (do_drop && is_last) begin
                skip_next = ~skip_reg;
                if (stat_reg != '1) begin
                    stat_next = stat_reg + SKIP_CNT_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            word_cnt_reg   <= '0;
            chunk_cnt_reg  <= '0;
            credits_reg    <= '0;
            stat_reg       <= '0;
            wr_en_reg      <= 1'b0;
            wr_data_reg    <= '0;
            skip_reg       <= 1'b0;
            fill_reg       <= 1'b0;
            mlow_reg       <= 1'b0;
            cfg_sz_reg     <= '0;
            cfg_dis_reg    <= 1'b0;
            cfg_brst_z_reg <= '0;
            cfg_ring_z_reg <= '0;
        end else begin
            state_reg     <= state_next;
            word_cnt_reg  <= word_cnt_next;
            chunk_cnt_reg <= chunk_cnt_next;
            credits_reg   <= credits_next;
            stat_reg      <= stat_next;
            wr_en_reg     <= wr_en_next;
            wr_data_reg   <= wr_data_next;
            skip_reg      <= skip_next;
            fill_reg      <= fill_next;
            mlow_reg      <= mlow_next;
            if (!dma_en) begin
                cfg_sz_reg     <= cfg_max_payload_sz;
                cfg_dis_reg    <= cfg_dis_lowwmrk;
                cfg_brst_z_reg <= cfg_brst_words_z;
                cfg_ring_z_reg <= cfg_ring_bursts_z;
            end
        end
    end

    assign fifo_wr_en         = wr_en_reg;
    assign fifo_wr_data       = wr_data_reg;
    assign fifo_burst_skip    = skip_reg;
    assign fifo_burst_fill    = fill_reg;
    assign fifo_burst_mlowmrk = mlow_reg;
    assign stat_skipped       = stat_reg;
    assign credits            = credits_reg;

endmodule

// File: tb/tb_burstbuffer_to_bsig.sv
module tb_burstbuffer_to_bsig;

    localparam int DATA_BITS        = 4;
    localparam int BUFFER_SIZE_BITS = 16;
    localparam int RING_BITS        = 6;
    localparam int SKIP_CNT_BITS    = 24;
    localparam int WORD_W           = 8 << DATA_BITS;
    localparam int CNT_W            = BUFFER_SIZE_BITS - DATA_BITS;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     dma_en;
    logic [1:0]               cfg_max_payload_sz;
    logic                     cfg_dis_lowwmrk;
    logic [CNT_W-1:0]         cfg_brst_words_z;
    logic [RING_BITS-1:0]     cfg_ring_bursts_z;
    logic                     burst_release;
    logic                     in_valid;
    logic [WORD_W-1:0]        in_data;
    logic                     fifo_wr_en;
    logic [WORD_W-1:0]        fifo_wr_data;
    logic                     fifo_burst_skip;
    logic                     fifo_burst_fill;
    logic                     fifo_burst_mlowmrk;
    logic [SKIP_CNT_BITS-1:0] stat_skipped;
    logic [RING_BITS:0]       credits;

    int checks   = 0;
    int failures = 0;

    // Per-burst observation counters, filled in by cyc().
    int n_wr, n_fill, n_skip, n_mlow, n_data_bad;
    int fill_at, skip_at, mlow_at, word_idx;
    logic prev_skip, prev_fill, prev_mlow;
    logic [WORD_W-1:0] data_seq = '0;

    burstbuffer_to_bsig #(
        .DATA_BITS(DATA_BITS),
        .BUFFER_SIZE_BITS(BUFFER_SIZE_BITS),
        .RING_BITS(RING_BITS),
        .EN_LOWWMRK(1),
        .SKIP_CNT_BITS(SKIP_CNT_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dma_en(dma_en),
        .cfg_max_payload_sz(cfg_max_payload_sz),
        .cfg_dis_lowwmrk(cfg_dis_lowwmrk),
        .cfg_brst_words_z(cfg_brst_words_z),
        .cfg_ring_bursts_z(cfg_ring_bursts_z),
        .burst_release(burst_release),
        .in_valid(in_valid),
        .in_data(in_data),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_burst_skip(fifo_burst_skip),
        .fifo_burst_fill(fifo_burst_fill),
        .fifo_burst_mlowmrk(fifo_burst_mlowmrk),
        .stat_skipped(stat_skipped),
        .credits(credits)
    );

    always #5 clk = ~clk;

    task automatic clear_obs();
        n_wr = 0; n_fill = 0; n_skip = 0; n_mlow = 0; n_data_bad = 0;
        fill_at = 0; skip_at = 0; mlow_at = 0; word_idx = 0;
    endtask

    // One clock: drive on the falling edge, observe 1 time unit after the rise.
    task automatic cyc(input logic v, input logic rel);
        logic [WORD_W-1:0] d;
        @(negedge clk);
        data_seq      = data_seq + WORD_W'(1);
        d             = {data_seq[31:0], ~data_seq[31:0], data_seq[31:0], 32'hA5A5_0000};
        in_valid      = v;
        burst_release = rel;
        in_data       = d;
        if (v) word_idx = word_idx + 1;
        @(posedge clk);
        #1;
        if (fifo_wr_en) begin
            n_wr = n_wr + 1;
            if (fifo_wr_data !== d) n_data_bad = n_data_bad + 1;
        end
        if (fifo_burst_fill !== prev_fill) begin n_fill = n_fill + 1; fill_at = word_idx; end
        if (fifo_burst_skip !== prev_skip) begin n_skip = n_skip + 1; skip_at = word_idx; end
        if (fifo_burst_mlowmrk !== prev_mlow) begin
            n_mlow = n_mlow + 1;
            if (mlow_at == 0) mlow_at = word_idx;
        end
        prev_fill = fifo_burst_fill;
        prev_skip = fifo_burst_skip;
        prev_mlow = fifo_burst_mlowmrk;
    endtask

    // Send n back-to-back words; release pulsed on word rel_at (1-based, 0 = none).
    task automatic burst(input int n, input int rel_at);
        clear_obs();
        for (int i = 1; i <= n; i++) cyc(1'b1, (i == rel_at));
        @(negedge clk);
        in_valid = 1'b0;
        burst_release = 1'b0;
    endtask

    task automatic configure(input logic [1:0] sz, input logic dis,
                             input int brst_z, input int ring_z);
        @(negedge clk);
        dma_en             = 1'b0;
        in_valid           = 1'b0;
        cfg_max_payload_sz = sz;
        cfg_dis_lowwmrk    = dis;
        cfg_brst_words_z   = CNT_W'(brst_z);
        cfg_ring_bursts_z  = RING_BITS'(ring_z);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        @(negedge clk);
        dma_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; dma_en = 1'b0; in_valid = 1'b0; burst_release = 1'b0; in_data = '0;
        cfg_max_payload_sz = 2'd0; cfg_dis_lowwmrk = 1'b0;
        cfg_brst_words_z = '0; cfg_ring_bursts_z = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fifo_wr_en, fifo_burst_skip, fifo_burst_fill, fifo_burst_mlowmrk} !== 4'b0) begin
            failures++; $display("FAIL reset_flags got=%b%b%b%b want=0000",
                fifo_wr_en, fifo_burst_skip, fifo_burst_fill, fifo_burst_mlowmrk);
        end
        checks++;
        if (fifo_wr_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", fifo_wr_data); end
        checks++;
        if (stat_skipped !== '0 || credits !== '0) begin
            failures++; $display("FAIL reset_counts stat=%0d credits=%0d want 0/0", stat_skipped, credits);
        end
        $display("test_reset: outputs after reset checked");
        @(negedge clk);
        rst = 1'b0;
        prev_fill = 1'b0; prev_skip = 1'b0; prev_mlow = 1'b0;
    endtask

    task automatic test_fill();
        configure(2'd0, 1'b0, 15, 3);
        checks++;
        if (credits !== 7'd4) begin failures++; $display("FAIL fill_credit_load got=%0d want=4", credits); end
        burst(16, 0);
        checks++;
        if (n_wr != 16) begin failures++; $display("FAIL fill_wr_count got=%0d want=16", n_wr); end
        checks++;
        if (n_data_bad != 0) begin failures++; $display("FAIL fill_data bad_words=%0d want=0", n_data_bad); end
        checks++;
        if (n_mlow != 1 || mlow_at != 8) begin
            failures++; $display("FAIL fill_mlowmrk count=%0d at=%0d want 1 at 8", n_mlow, mlow_at);
        end
        checks++;
        if (n_fill != 1 || fill_at != 16) begin
            failures++; $display("FAIL fill_toggle count=%0d at=%0d want 1 at 16", n_fill, fill_at);
        end
        checks++;
        if (n_skip != 0 || credits !== 7'd3) begin
            failures++; $display("FAIL fill_state skips=%0d credits=%0d want 0/3", n_skip, credits);
        end
        $display("test_fill: wr=%0d fill=%0d mlow=%0d credits=%0d", n_wr, n_fill, n_mlow, credits);
    endtask

    task automatic test_skip();
        configure(2'd0, 1'b0, 15, 1);
        burst(16, 0);
        checks++;
        if (n_fill != 1 || n_wr != 16) begin failures++; $display("FAIL skip_b1 fill=%0d wr=%0d want 1/16", n_fill, n_wr); end
        burst(16, 0);
        checks++;
        if (n_fill != 1 || n_wr != 16) begin failures++; $display("FAIL skip_b2 fill=%0d wr=%0d want 1/16", n_fill, n_wr); end
        burst(16, 0);
        checks++;
        if (n_wr != 0 || n_fill != 0) begin failures++; $display("FAIL skip_b3_writes wr=%0d fill=%0d want 0/0", n_wr, n_fill); end
        checks++;
        if (n_skip != 1 || skip_at != 16 || n_mlow != 0) begin
            failures++; $display("FAIL skip_b3_toggle count=%0d at=%0d mlow=%0d want 1 at 16, mlow 0", n_skip, skip_at, n_mlow);
        end
        checks++;
        if (stat_skipped !== 24'd1 || credits !== 7'd0) begin
            failures++; $display("FAIL skip_counts stat=%0d credits=%0d want 1/0", stat_skipped, credits);
        end
        $display("test_skip: stat=%0d credits=%0d", stat_skipped, credits);
    endtask

    task automatic test_release_in_skip();
        burst(16, 5);
        checks++;
        if (n_wr != 0 || n_skip != 1 || stat_skipped !== 24'd2) begin
            failures++; $display("FAIL relskip_b4 wr=%0d skip=%0d stat=%0d want 0/1/2", n_wr, n_skip, stat_skipped);
        end
        checks++;
        if (credits !== 7'd1) begin failures++; $display("FAIL relskip_credit got=%0d want=1", credits); end
        burst(16, 0);
        checks++;
        if (n_fill != 1 || n_wr != 16 || credits !== 7'd0) begin
            failures++; $display("FAIL relskip_b5 fill=%0d wr=%0d credits=%0d want 1/16/0", n_fill, n_wr, credits);
        end
        $display("test_release_in_skip: stat=%0d credits=%0d", stat_skipped, credits);
    endtask

    task automatic test_same_cycle_release();
        burst(16, 1);
        checks++;
        if (n_fill != 1 || n_wr != 16 || n_skip != 0) begin
            failures++; $display("FAIL samecyc fill=%0d wr=%0d skip=%0d want 1/16/0", n_fill, n_wr, n_skip);
        end
        checks++;
        if (credits !== 7'd0 || stat_skipped !== 24'd2) begin
            failures++; $display("FAIL samecyc_counts credits=%0d stat=%0d want 0/2", credits, stat_skipped);
        end
        $display("test_same_cycle_release: fill=%0d credits=%0d", n_fill, credits);
    endtask

    task automatic test_no_mlowmrk();
        configure(2'd3, 1'b0, 15, 3);
        burst(16, 0);
        checks++;
        if (n_mlow != 0 || n_fill != 1) begin failures++; $display("FAIL nomlow_big_chunk mlow=%0d fill=%0d want 0/1", n_mlow, n_fill); end
        configure(2'd0, 1'b1, 15, 3);
        burst(16, 0);
        checks++;
        if (n_mlow != 0 || n_fill != 1 || n_wr != 16) begin
            failures++; $display("FAIL nomlow_disabled mlow=%0d fill=%0d wr=%0d want 0/1/16", n_mlow, n_fill, n_wr);
        end
        $display("test_no_mlowmrk: mlow=%0d fill=%0d", n_mlow, n_fill);
    endtask

    task automatic test_abort();
        configure(2'd0, 1'b0, 15, 3);
        burst(5, 0);
        dma_en = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        checks++;
        if (n_fill != 0 || n_skip != 0 || n_wr != 5) begin
            failures++; $display("FAIL abort_partial fill=%0d skip=%0d wr=%0d want 0/0/5", n_fill, n_skip, n_wr);
        end
        checks++;
        if (credits !== 7'd4) begin failures++; $display("FAIL abort_reload got=%0d want=4", credits); end
        @(negedge clk);
        in_valid = 1'b0;
        dma_en = 1'b1;
        burst(16, 0);
        checks++;
        if (n_fill != 1 || fill_at != 16 || n_mlow != 1 || n_wr != 16) begin
            failures++; $display("FAIL abort_next fill=%0d at=%0d mlow=%0d wr=%0d want 1/16/1/16", n_fill, fill_at, n_mlow, n_wr);
        end
        $display("test_abort: next burst fill=%0d credits=%0d", n_fill, credits);
    endtask

    task automatic test_back_to_back();
        // One-word bursts: every word is its own burst.
        configure(2'd0, 1'b0, 0, 3);
        burst(5, 0);
        checks++;
        if (n_fill != 4 || n_wr != 4 || n_mlow != 0) begin
            failures++; $display("FAIL b2b_fill fill=%0d wr=%0d mlow=%0d want 4/4/0", n_fill, n_wr, n_mlow);
        end
        checks++;
        if (n_skip != 1 || skip_at != 5 || stat_skipped !== 24'd1 || credits !== 7'd0) begin
            failures++; $display("FAIL b2b_skip skip=%0d at=%0d stat=%0d credits=%0d want 1/5/1/0",
                n_skip, skip_at, stat_skipped, credits);
        end
        $display("test_back_to_back: fill=%0d skip=%0d", n_fill, n_skip);
    endtask

    task automatic test_reset_mid_burst();
        configure(2'd0, 1'b0, 15, 3);
        burst(16, 0);
        burst(10, 0);
        checks++;
        if ({fifo_burst_fill, fifo_burst_mlowmrk} === 2'b00) begin
            failures++; $display("FAIL midrst_pre fill=%b mlow=%b want a nonzero level", fifo_burst_fill, fifo_burst_mlowmrk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({fifo_burst_skip, fifo_burst_fill, fifo_burst_mlowmrk, fifo_wr_en} !== 4'b0 || credits !== '0) begin
            failures++; $display("FAIL midrst_toggles got=%b%b%b wr=%b credits=%0d want 000/0/0",
                fifo_burst_skip, fifo_burst_fill, fifo_burst_mlowmrk, fifo_wr_en, credits);
        end
        $display("test_reset_mid_burst: toggles after reset checked");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_skip();
        test_release_in_skip();
        test_same_cycle_release();
        test_no_mlowmrk();
        test_abort();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
